// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state encoding and default geometry for the scan-testable multiplier.
package scan_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2
   } state_t;
   localparam int DEF_WIDTH  = 4;
   localparam int DEF_CHAINS = 1;
endpackage

// File: rtl/param_scan_mul_chain_if.sv
// param_scan_mul_chain_if: tester/BIST-facing control and observation bundle of the scan multiplier.
interface param_scan_mul_chain_if
   import scan_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CHAINS = DEF_CHAINS
);
   logic                 scan_en;
   logic                 capture_en;
   logic                 start;
   logic [CHAINS-1:0]    scan_in;
   logic [CHAINS-1:0]    scan_out;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   modport master (output scan_en, capture_en, start, scan_in, input scan_out, busy, done, product);
   modport slave  (input scan_en, capture_en, start, scan_in, output scan_out, busy, done, product);
endinterface

// File: rtl/scan_seg.sv
// scan_seg: one L-bit scan chain segment with shift/capture/hold muxing and a registered serial output.
module scan_seg #(
   parameter int L = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift_i,
   input  logic         capture_i,
   input  logic         scan_i,
   input  logic [L-1:0] cap_i,
   output logic [L-1:0] seg_o,
   output logic         scan_o
);
   logic [L-1:0] seg_q, seg_d;
   logic         so_q, so_d;
   logic [L:0]   sh;
   always_comb begin
      sh    = {scan_i, seg_q};
      seg_d = shift_i ? sh[L:1] : capture_i ? cap_i : seg_q;
      so_d  = shift_i ? seg_q[0] : so_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q <= '0;
         so_q  <= 1'b0;
      end else begin
         seg_q <= seg_d;
         so_q  <= so_d;
      end
   end
   assign seg_o  = seg_q;
   assign scan_o = so_q;
endmodule

// File: rtl/param_scan_mul_chain.sv
// param_scan_mul_chain: scan-testable WIDTH x WIDTH unsigned multiplier whose operand register is split into CHAINS chains,
// with manual shift/capture and an auto load/unload+capture sequencer.
module param_scan_mul_chain
   import scan_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CHAINS = DEF_CHAINS
) (
   input logic                    clk,
   input logic                    rst_n,
   param_scan_mul_chain_if.slave  scan_if
);
   localparam int N  = 2 * WIDTH;
   localparam int L  = N / CHAINS;
   localparam int CW = (L > 1) ? $clog2(L) : 1;
   if ((N % CHAINS) != 0) begin : g_bad_chains
      $error("param_scan_mul_chain: 2*WIDTH must be a multiple of CHAINS");
   end
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, done_q;
   logic              shift_en, cap_en;
   logic [N-1:0]      r, prod;
   logic [CHAINS-1:0] so;
   assign prod = {{WIDTH{1'b0}}, r[WIDTH-1:0]} * {{WIDTH{1'b0}}, r[N-1:WIDTH]};
   for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      scan_seg #(.L(L)) u_seg (
         .clk       (clk),
         .rst_n     (rst_n),
         .shift_i   (shift_en),
         .capture_i (cap_en),
         .scan_i    (scan_if.scan_in[c]),
         .cap_i     (prod[c*L +: L]),
         .seg_o     (r[c*L +: L]),
         .scan_o    (so[c])
      );
   end
   // start wins over manual controls; no register op happens in the accepting cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_en = 1'b0;
      cap_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (scan_if.start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               shift_en = scan_if.scan_en;
               cap_en   = !scan_if.scan_en && scan_if.capture_en;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt_q == CW'(L - 1)) state_d = CAPTURE;
            else cnt_d = cnt_q + 1'b1;
         end
         CAPTURE: begin
            cap_en  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= state_d != IDLE;
         done_q  <= state_q == CAPTURE;
      end
   end
   assign scan_if.scan_out = so;
   assign scan_if.busy     = busy_q;
   assign scan_if.done     = done_q;
   assign scan_if.product  = prod;
endmodule

// File: tb/tb_param_scan_mul_chain.sv
// tb_param_scan_mul_chain: scoreboard bench for a single-chain (W4,C1) and a dual-chain (W4,C2) instance.
module tb_param_scan_mul_chain;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [1:0] sb[$];
   always #5 clk = ~clk;
   param_scan_mul_chain_if #(.WIDTH(4), .CHAINS(1)) if1 ();
   param_scan_mul_chain_if #(.WIDTH(4), .CHAINS(2)) if2 ();
   param_scan_mul_chain #(.WIDTH(4), .CHAINS(1)) u1 (.clk(clk), .rst_n(rst_n), .scan_if(if1));
   param_scan_mul_chain #(.WIDTH(4), .CHAINS(2)) u2 (.clk(clk), .rst_n(rst_n), .scan_if(if2));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic load1(input logic [7:0] v);
      for (int k = 0; k < 8; k++) begin
         if1.scan_en = 1'b1;
         if1.scan_in = v[k];
         tick();
      end
      if1.scan_en = 1'b0;
      if1.scan_in = 1'b0;
   endtask
   task automatic unload1(input logic [7:0] v, input logic both_first);
      for (int k = 0; k < 8; k++) begin
         sb.push_back({1'b0, v[k]});
         if1.scan_en    = 1'b1;
         if1.capture_en = both_first && (k == 0);
         if1.scan_in    = 1'b0;
         tick();
         chk("unload1", {1'b0, if1.scan_out}, sb.pop_front());
      end
      if1.scan_en    = 1'b0;
      if1.capture_en = 1'b0;
   endtask
   task automatic run_auto(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] e0,
                           input logic [3:0] e1, input logic [1:0] hold);
      int n, nb;
      if2.start      = 1'b1;
      if2.scan_en    = 1'b1;
      if2.capture_en = 1'b1;
      if2.scan_in    = 2'b11;
      tick();
      n  = 1;
      nb = int'(if2.busy);
      if2.start      = 1'b0;
      if2.scan_en    = 1'b0;
      if2.capture_en = 1'b0;
      chk("auto_start_no_shift", if2.scan_out, hold);
      chk("auto_done_clear", if2.done, 0);
      for (int k = 0; k < 4; k++) begin
         sb.push_back({e1[k], e0[k]});
         if2.scan_in    = {c1[k], c0[k]};
         if2.start      = (k == 1);
         if2.capture_en = (k == 2);
         tick();
         n++;
         nb += int'(if2.busy);
         chk("auto_unload", if2.scan_out, sb.pop_front());
      end
      if2.start      = 1'b0;
      if2.capture_en = 1'b0;
      chk("auto_pre_cap_prod", if2.product, 8'h0F);
      while (!if2.done && n < 20) begin
         tick();
         n++;
         nb += int'(if2.busy);
      end
      chk("auto_busy_cycles", nb, 5);
      chk("auto_done_edge", n, 6);
      chk("auto_post_cap_prod", if2.product, 8'h00);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      {if1.scan_en, if1.capture_en, if1.start, if1.scan_in} = '0;
      {if2.scan_en, if2.capture_en, if2.start, if2.scan_in} = '0;
      tick();
      tick();
      chk("rst_busy", {if1.busy, if2.busy}, 0);
      chk("rst_done", {if1.done, if2.done}, 0);
      chk("rst_prod", {if1.product, if2.product}, 0);
      chk("rst_so", {if1.scan_out, if2.scan_out}, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if2.scan_en = 1'b1;
         if2.scan_in = 2'b11;
         tick();
      end
      if2.scan_en = 1'b0;
      chk("c2_load_prod", if2.product, 8'hE1);
      if2.start = 1'b1;
      tick();
      if2.start = 1'b0;
      tick();
      tick();
      chk("mid_busy", if2.busy, 1);
      chk("mid_so", if2.scan_out, 2'b11);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_busy", if2.busy, 0);
      chk("mid_rst_done", if2.done, 0);
      chk("mid_rst_prod", if2.product, 8'h00);
      chk("mid_rst_so", if2.scan_out, 2'b00);
      load1(8'h53);
      chk("m_load_prod", if1.product, 8'h0F);
      repeat (10) tick();
      chk("hold_prod", if1.product, 8'h0F);
      chk("hold_so", if1.scan_out, 1'b0);
      if1.capture_en = 1'b1;
      tick();
      if1.capture_en = 1'b0;
      chk("m_cap_prod", if1.product, 8'h00);
      unload1(8'h0F, 1'b0);
      load1(8'hFF);
      chk("max_prod", if1.product, 8'hE1);
      if1.capture_en = 1'b1;
      tick();
      if1.capture_en = 1'b0;
      chk("max_cap_prod", if1.product, 8'h0E);
      unload1(8'hE1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         if2.scan_en = 1'b1;
         if2.scan_in = 2'b11;
         tick();
      end
      if2.scan_en = 1'b0;
      run_auto(4'b0011, 4'b0101, 4'b1111, 4'b1111, 2'b00);
      run_auto(4'b0011, 4'b0101, 4'b1111, 4'b0000, 2'b11);
      tick();
      chk("single_done", if2.done, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
